rptr_wsync_monitor: RTL and testbench
=====================================

Name: rptr_wsync_monitor

Overview:
- Write-domain receiver for the read pointer in the async FIFO pointer crossing.
- Takes the Gray read pointer from the read domain and synchronizes it into wclk through a SYNC_STAGES flop chain. It also converts the pointer to binary.
- Computes a registered write-side fill level and almost_full, and flags protocol errors: multi-bit Gray jumps and writes attempted while full.
- Sits beside the write pointer handler. Its g_rptr_sync output feeds that handler's full comparison.

Parameters:
- PTR_WIDTH, 3: pointer address bits; DEPTH = 2^PTR_WIDTH; all pointers are PTR_WIDTH+1 bits wide.
- SYNC_STAGES, 2: synchronizer flop count; legal range 2..4.
- AF_THRESH, 6: almost_full asserts when wr_level >= AF_THRESH; legal range 1..DEPTH.

Ports:
- wclk  input  1  write clock.
- wrst_n  input  1  asynchronous, active-low reset, write domain.
- g_rptr  input  PTR_WIDTH+1  Gray read pointer, launched from rclk flops; treated as asynchronous.
- b_wptr  input  PTR_WIDTH+1  binary write pointer (wclk domain, registered).
- w_en  input  1  write request this cycle.
- full  input  1  registered full flag from the write pointer handler.
- err_clr  input  1  synchronous clear of sticky error flags.
- g_rptr_sync  output  PTR_WIDTH+1  last synchronizer stage.
- b_rptr_sync  output  PTR_WIDTH+1  registered binary conversion of g_rptr_sync.
- wr_level  output  PTR_WIDTH+1  registered occupancy, 0..DEPTH.
- almost_full  output  1  registered level threshold flag.
- gray_err  output  1  sticky: synchronized Gray pointer changed by more than 1 bit between consecutive cycles.
- level_err  output  1  sticky: computed level exceeded DEPTH.
- overflow_err  output  1  sticky: w_en asserted while full.

Behaviour:
- Reset (async assert, sync-to-wclk release by the system): every sync stage, g_rptr_sync, b_rptr_sync, the previous-sample register, wr_level, almost_full and all error flags go to 0. The warm-up counter loads 0.
- Synchronizer: plain flop chain, no logic between stages. A stable g_rptr change appears on g_rptr_sync at the SYNC_STAGES-th wclk edge.
- Gray-to-binary: b[i] = XOR of g[PTR_WIDTH:i]. The result is registered into b_rptr_sync, 1 cycle after g_rptr_sync.
- Level: lvl_next = (b_wptr - b_rptr_sync), unsigned, mod 2^(PTR_WIDTH+1). It is registered into wr_level, 1 cycle after b_rptr_sync or b_wptr changes.
- almost_full is registered from (lvl_next >= AF_THRESH) on the same edge as wr_level.
- Wrap-around is handled by the modular subtraction. Pointers differing only in MSB give level = DEPTH.
- level_err is set when lvl_next > DEPTH, and only after warm-up completes.
- gray_err: a previous-sample register holds the last g_rptr_sync value. gray_err is set when popcount(g_rptr_sync ^ prev) > 1.
- Warm-up: a counter counts SYNC_STAGES+2 wclk cycles after reset release. gray_err and level_err are suppressed until the count completes; this covers a read domain still holding a non-zero pointer. overflow_err is never suppressed.
- overflow_err is set on any edge where w_en=1 and full=1.
- err_clr: all sticky flags go to 0 on the next edge. If a set condition and err_clr occur on the same edge, set wins.
- The block never modifies either pointer. It is observation only, apart from forwarding g_rptr_sync.
- Reset asserted mid-operation: all state clears immediately and warm-up restarts.

Optional Feature:
- Macro: WR_LEVEL_STATS_EN.
- Defined: adds the following outputs.
  - peak_level [PTR_WIDTH:0]: maximum registered wr_level since reset or err_clr. On err_clr it reloads with the current lvl_next.
  - ovf_count [7:0]: saturating count (stops at 255) of overflow cycles. It is cleared by err_clr; if an overflow occurs on the clearing edge, it loads 1.
- Not defined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset, PTR_WIDTH=3, g_rptr=0, b_wptr=0: all outputs 0 until the first write.
- g_rptr held 0, b_wptr stepped 0..6 once per cycle: wr_level tracks b_wptr with 1-cycle lag. almost_full=1 on the same edge wr_level becomes 6.
- After warm-up, g_rptr steps 0000 to 0001:
  - g_rptr_sync=0001 after 2 edges.
  - b_rptr_sync=0001 after 3 edges.
  - wr_level drops by 1 after 4 edges.
- Wrap: b_wptr=1001 with binary read pointer 0010 gives wr_level=7. b_wptr=0001 with read pointer 1001 gives wr_level=8, almost_full=1, level_err=0.
- After warm-up, g_rptr jumps 0000 to 0011: gray_err=1 and stays set. err_clr pulse clears it. The same jump inside warm-up leaves gray_err=0.
- full=1 with w_en=1 for one cycle: overflow_err=1 next edge. With WR_LEVEL_STATS_EN, 300 such cycles give ovf_count=255 and err_clr clears it to 0.

Source files
------------

// File: rtl/rptr_wsync_monitor_if.sv
// Read-pointer crossing bundle between the write-domain monitor (slave) and its driver (master).
// Build macro WR_LEVEL_STATS_EN adds the peak_level / ovf_count statistics signals.
interface rptr_wsync_monitor_if #(
    parameter int PTR_WIDTH = 3
);
    logic [PTR_WIDTH:0] g_rptr;
    logic [PTR_WIDTH:0] b_wptr;
    logic               w_en;
    logic               full;
    logic               err_clr;
    logic [PTR_WIDTH:0] g_rptr_sync;
    logic [PTR_WIDTH:0] b_rptr_sync;
    logic [PTR_WIDTH:0] wr_level;
    logic               almost_full;
    logic               gray_err;
    logic               level_err;
    logic               overflow_err;
`ifdef WR_LEVEL_STATS_EN
    logic [PTR_WIDTH:0] peak_level;
    logic [7:0]         ovf_count;
`endif

    modport master (
        output g_rptr, b_wptr, w_en, full, err_clr,
        input  g_rptr_sync, b_rptr_sync, wr_level, almost_full,
        input  gray_err, level_err, overflow_err
`ifdef WR_LEVEL_STATS_EN
        , input peak_level, ovf_count
`endif
    );

    modport slave (
        input  g_rptr, b_wptr, w_en, full, err_clr,
        output g_rptr_sync, b_rptr_sync, wr_level, almost_full,
        output gray_err, level_err, overflow_err
`ifdef WR_LEVEL_STATS_EN
        , output peak_level, ovf_count
`endif
    );
endinterface

// File: rtl/rptr_wsync_monitor.sv
// Write-domain receiver for the Gray read pointer: synchronizer, binary conversion, fill level and
// protocol-error flags. Build macro WR_LEVEL_STATS_EN adds peak_level and ovf_count.
module rptr_wsync_monitor #(
    parameter int PTR_WIDTH   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 6
) (
    input logic                 wclk,
    input logic                 wrst_n,
    rptr_wsync_monitor_if.slave bus
);
    typedef logic [PTR_WIDTH:0] ptr_t;

    localparam int   DEPTH  = 1 << PTR_WIDTH;
    localparam int   WARM   = SYNC_STAGES + 2;
    localparam int   CNT_W  = $clog2(WARM + 1);
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t AF_P    = ptr_t'(AF_THRESH);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
        $error("AF_THRESH must be in 1..DEPTH");
    end

    logic [SYNC_STAGES-1:0][PTR_WIDTH:0] sync_q;
    ptr_t             g_sync;
    ptr_t             prev_q;
    ptr_t             b_rptr_q, b_rptr_d;
    ptr_t             wr_level_q;
    ptr_t             lvl_next;
    ptr_t             diff;
    logic             af_q;
    logic             gray_err_q, gray_err_d;
    logic             level_err_q, level_err_d;
    logic             ovf_err_q, ovf_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             warm_done;
    logic             gray_set, level_set, ovf_set;

    assign g_sync    = sync_q[SYNC_STAGES-1];
    assign lvl_next  = bus.b_wptr - b_rptr_q;
    assign warm_done = (cnt_q == CNT_W'(WARM));
    assign diff      = g_sync ^ prev_q;

    always_comb begin
        b_rptr_d = '0;
        for (int i = 0; i <= PTR_WIDTH; i++) begin
            b_rptr_d[i] = ^(g_sync >> i);
        end
    end

    // Clearing the lowest set bit leaves a residue only if more than one bit flipped.
    always_comb begin
        gray_set  = warm_done && ((diff & (diff - ptr_t'(1))) != '0);
        level_set = warm_done && (lvl_next > DEPTH_P);
        ovf_set   = bus.w_en && bus.full;
        cnt_d     = warm_done ? cnt_q : cnt_q + 1'b1;
        // A set condition on the clearing edge takes priority.
        gray_err_d  = gray_set  | (gray_err_q  & ~bus.err_clr);
        level_err_d = level_set | (level_err_q & ~bus.err_clr);
        ovf_err_d   = ovf_set   | (ovf_err_q   & ~bus.err_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            sync_q      <= '0;
            prev_q      <= '0;
            b_rptr_q    <= '0;
            wr_level_q  <= '0;
            af_q        <= 1'b0;
            gray_err_q  <= 1'b0;
            level_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.g_rptr};
            prev_q      <= g_sync;
            b_rptr_q    <= b_rptr_d;
            wr_level_q  <= lvl_next;
            af_q        <= (lvl_next >= AF_P);
            gray_err_q  <= gray_err_d;
            level_err_q <= level_err_d;
            ovf_err_q   <= ovf_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.g_rptr_sync  = g_sync;
    assign bus.b_rptr_sync  = b_rptr_q;
    assign bus.wr_level     = wr_level_q;
    assign bus.almost_full  = af_q;
    assign bus.gray_err     = gray_err_q;
    assign bus.level_err    = level_err_q;
    assign bus.overflow_err = ovf_err_q;

`ifdef WR_LEVEL_STATS_EN
    ptr_t       peak_q, peak_d;
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        peak_d    = peak_q;
        ovf_cnt_d = ovf_cnt_q;
        if (bus.err_clr) begin
            peak_d    = lvl_next;
            ovf_cnt_d = ovf_set ? 8'd1 : 8'd0;
        end else begin
            if (lvl_next > peak_q) peak_d = lvl_next;
            if (ovf_set && (ovf_cnt_q != 8'hff)) ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            peak_q    <= '0;
            ovf_cnt_q <= '0;
        end else begin
            peak_q    <= peak_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign bus.peak_level = peak_q;
    assign bus.ovf_count  = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_rptr_wsync_monitor.sv
// Directed bench for rptr_wsync_monitor: expected outputs are queued with a due cycle when
// stimulus is driven and compared when that cycle arrives.
module tb_rptr_wsync_monitor;
    localparam int PW = 3;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b0;

    rptr_wsync_monitor_if #(.PTR_WIDTH(PW)) bus ();

    rptr_wsync_monitor #(
        .PTR_WIDTH  (PW),
        .SYNC_STAGES(2),
        .AF_THRESH  (6)
    ) dut (
        .wclk  (wclk),
        .wrst_n(wrst_n),
        .bus   (bus)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   passed;
    int   total;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            0: return 32'(bus.g_rptr_sync);
            1: return 32'(bus.b_rptr_sync);
            2: return 32'(bus.wr_level);
            3: return 32'(bus.almost_full);
            4: return 32'(bus.gray_err);
            5: return 32'(bus.level_err);
            6: return 32'(bus.overflow_err);
`ifdef WR_LEVEL_STATS_EN
            7: return 32'(bus.peak_level);
            8: return 32'(bus.ovf_count);
`endif
            default: return 'x;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic expect_at(int dly, int sel, logic [31:0] v, string tag);
        sb.push_back('{cyc + dly, sel, v, tag});
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].tag, observe(sb[i].sel), sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() > 0; n++) tick();
        if (sb.size() != 0) begin
            total++;
            $error("FAIL drain: observed %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero(string tag);
        for (int s = 0; s <= 6; s++) check($sformatf("%s_%0d", tag, s), observe(s), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0; passed = 0; total = 0;
        bus.g_rptr = '0; bus.b_wptr = '0; bus.w_en = 1'b0; bus.full = 1'b0; bus.err_clr = 1'b0;

        // Reset and idle state
        repeat (3) @(posedge wclk);
        #1;
        check_zero("rst");
        wrst_n = 1'b1;
        repeat (3) tick();
        check_zero("idle");

        // Write pointer ramp with read pointer held at zero
        for (int i = 1; i <= 6; i++) begin
            bus.b_wptr = 4'(i);
            expect_at(1, 2, 32'(i), $sformatf("lvl_step%0d", i));
            expect_at(1, 3, 32'(i >= 6), $sformatf("af_step%0d", i));
            tick();
        end
        drain();
`ifdef WR_LEVEL_STATS_EN
        check("peak_ramp", observe(7), 32'd6);
`endif

        // Single read-pointer step: latency through sync, binary and level stages
        bus.g_rptr = 4'b0001;
        expect_at(1, 0, 32'd0, "gsync_lat1");
        expect_at(2, 0, 32'd1, "gsync_lat2");
        expect_at(2, 1, 32'd0, "bsync_lat2");
        expect_at(3, 1, 32'd1, "bsync_lat3");
        expect_at(3, 2, 32'd6, "lvl_lat3");
        expect_at(4, 2, 32'd5, "lvl_lat4");
        expect_at(5, 4, 32'd0, "gray_1bit");
        drain();

        // Wrap-around: wptr 1001, rptr binary 0010 (Gray 0011)
        bus.g_rptr = 4'b0011;
        bus.b_wptr = 4'b1001;
        expect_at(4, 2, 32'd7, "wrap_lvl7");
        expect_at(4, 3, 32'd1, "wrap_af7");
        drain();
        for (int b = 3; b <= 9; b++) begin
            bus.g_rptr = 4'(b ^ (b >> 1));
            tick();
        end
        repeat (4) tick();
        bus.b_wptr = 4'b0001;
        expect_at(1, 2, 32'd8, "wrap_lvl8");
        expect_at(1, 3, 32'd1, "wrap_af8");
        expect_at(1, 5, 32'd0, "wrap_lerr0");
        expect_at(1, 4, 32'd0, "walk_gerr0");
        drain();

        // Level beyond DEPTH after warm-up, then clear
        bus.b_wptr = 4'b1000;
        expect_at(1, 2, 32'd15, "lvl_raw15");
        expect_at(1, 5, 32'd1, "lerr_set");
        drain();
`ifdef WR_LEVEL_STATS_EN
        check("peak_15", observe(7), 32'd15);
`endif
        bus.b_wptr = 4'b1001;
        bus.err_clr = 1'b1;
        expect_at(1, 5, 32'd0, "lerr_clr");
`ifdef WR_LEVEL_STATS_EN
        expect_at(1, 7, 32'd0, "peak_reload");
`endif
        tick();
        bus.err_clr = 1'b0;
        drain();

        // Mid-operation reset clears asynchronously
        wrst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        bus.g_rptr = '0;
        bus.b_wptr = '0;
        tick();
        wrst_n = 1'b1;
        repeat (6) tick();

        // Multi-bit Gray jump after warm-up
        bus.g_rptr = 4'b0011;
        bus.b_wptr = 4'b0010;
        expect_at(2, 4, 32'd0, "gerr_pre");
        expect_at(3, 4, 32'd1, "gerr_set");
        expect_at(6, 4, 32'd1, "gerr_sticky");
        drain();
        bus.err_clr = 1'b1;
        expect_at(1, 4, 32'd0, "gerr_clr");
        tick();
        bus.err_clr = 1'b0;

        // Same jump inside warm-up is ignored; overflow is not suppressed
        wrst_n = 1'b0;
        bus.g_rptr = '0;
        bus.b_wptr = '0;
        tick();
        wrst_n = 1'b1;
        bus.g_rptr = 4'b0011;
        bus.b_wptr = 4'b0010;
        bus.w_en = 1'b1;
        bus.full = 1'b1;
        expect_at(1, 6, 32'd1, "ovf_warm");
        expect_at(3, 4, 32'd0, "gerr_warm");
        expect_at(8, 4, 32'd0, "gerr_warm_late");
        tick();
        bus.w_en = 1'b0;
        bus.full = 1'b0;
        drain();

        // Set wins over clear on the same edge
        bus.w_en = 1'b1;
        bus.full = 1'b1;
        bus.err_clr = 1'b1;
        expect_at(1, 6, 32'd1, "ovf_setwins");
`ifdef WR_LEVEL_STATS_EN
        expect_at(1, 8, 32'd1, "ovfcnt_setwins");
`endif
        tick();
        bus.w_en = 1'b0;
        bus.full = 1'b0;
        expect_at(1, 6, 32'd0, "ovf_clr");
        tick();
        bus.err_clr = 1'b0;
        bus.w_en = 1'b1;
        expect_at(1, 6, 32'd0, "ovf_wen_only");
        tick();
        bus.w_en = 1'b0;
        bus.full = 1'b1;
        expect_at(1, 6, 32'd0, "ovf_full_only");
        tick();
        bus.full = 1'b0;
        drain();

`ifdef WR_LEVEL_STATS_EN
        bus.w_en = 1'b1;
        bus.full = 1'b1;
        repeat (300) tick();
        bus.w_en = 1'b0;
        bus.full = 1'b0;
        check("ovfcnt_sat", observe(8), 32'd255);
        bus.err_clr = 1'b1;
        expect_at(1, 8, 32'd0, "ovfcnt_clr");
        tick();
        bus.err_clr = 1'b0;
        drain();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
